// File: rtl/chicken_pkg.sv
// Shared constants and helpers for the chicken board tracker.
// FSM state encodings, default track length, start-tile and wrap helpers.
package chicken_pkg;

  localparam int RING_LEN_DEF = 24;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READY   = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Evenly spaced home tile for a slot; unused slots sit on tile 0.
  function automatic int start_tile(
    input int idx,
    input int n,
    input int len = RING_LEN_DEF
  );
    if (n < 2 || idx >= n) return 0;
    return idx * (len / n);
  endfunction

  function automatic int wrap_inc(
    input int pos,
    input int len = RING_LEN_DEF
  );
    return (pos == len - 1) ? 0 : pos + 1;
  endfunction

endpackage

// File: rtl/chicken_ring_pos.sv
// One token position on the circular track.
// Ports: clk, rst, load_i/load_val_i (jump to tile), step_i (advance one), pos_o.
module chicken_ring_pos
  import chicken_pkg::*;
#(
  parameter int RING_LEN = 24,
  parameter int POS_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [POS_W-1:0] load_val_i,
  input  logic             step_i,
  output logic [POS_W-1:0] pos_o
);

  logic [POS_W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (load_i)
      pos_d = load_val_i;
    else if (step_i)
      pos_d = POS_W'(wrap_inc(int'(pos_q), RING_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/chicken_board_tracker.sv
// Multi-player token tracker: setup, turns, stepping, catches, win flag.
// Ports: start/N setup, move_valid/steps/ready handshake, positions, catches, winner.
module chicken_board_tracker
  import chicken_pkg::*;
#(
  parameter int MAX_PLAYERS  = 4,
  parameter int RING_LEN     = 24,
  parameter int POS_W        = 5,
  parameter int STEP_W       = 3,
  parameter int CATCH_TO_WIN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               N,
  input  logic                     start,
  input  logic                     move_valid,
  input  logic [STEP_W-1:0]        move_steps,
  output logic                     move_ready,
  output logic [2:0]               cur_player,
  output logic [MAX_PLAYERS*POS_W-1:0] pos_flat,
  output logic [MAX_PLAYERS-1:0]   active,
  output logic                     catch_pulse,
  output logic [2:0]               catch_victim,
  output logic [MAX_PLAYERS*3-1:0] catch_cnt_flat,
  output logic                     game_over,
  output logic [2:0]               winner
);

  logic [2:0]             state_q, state_d;
  logic [3:0]             n_q, n_d, n_clamp;
  logic [2:0]             cur_q, cur_d;
  logic [STEP_W-1:0]      rem_q, rem_d;
  logic [MAX_PLAYERS-1:0] act_q, act_d;
  logic [2:0]             cnt_q [MAX_PLAYERS];
  logic [2:0]             cnt_d [MAX_PLAYERS];
  logic                   go_q, go_d;
  logic [2:0]             win_q, win_d;

  logic [POS_W-1:0]       pos_w [MAX_PLAYERS];
  logic [POS_W-1:0]       load_val [MAX_PLAYERS];
  logic [MAX_PLAYERS-1:0] load, step;
  logic [POS_W-1:0]       mover_pos;
  logic [2:0]             mover_cnt, cnt_inc, nxt_player, victim;
  logic                   hit;

  always_comb begin
    if (N < 4'd2)                   n_clamp = 4'd2;
    else if (N > 4'(MAX_PLAYERS))   n_clamp = 4'(MAX_PLAYERS);
    else                            n_clamp = N;
  end

  // Landing-tile match; the descending scan leaves the lowest index.
  always_comb begin
    mover_pos = '0;
    mover_cnt = '0;
    for (int i = 0; i < MAX_PLAYERS; i++)
      if (3'(i) == cur_q) begin
        mover_pos = pos_w[i];
        mover_cnt = cnt_q[i];
      end
    hit    = 1'b0;
    victim = '0;
    for (int i = MAX_PLAYERS - 1; i >= 0; i--)
      if (act_q[i] && 3'(i) != cur_q && pos_w[i] == mover_pos) begin
        hit    = 1'b1;
        victim = 3'(i);
      end
  end

  assign cnt_inc    = (mover_cnt == 3'd7) ? 3'd7 : mover_cnt + 3'd1;
  assign nxt_player = ({1'b0, cur_q} + 4'd1 >= n_q) ? 3'd0 : cur_q + 3'd1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    act_d   = act_q;
    go_d    = go_q;
    win_d   = win_q;
    load    = '0;
    step    = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      cnt_d[i]    = cnt_q[i];
      load_val[i] = '0;
    end
    if (start) begin
      state_d = S_READY;
      n_d     = n_clamp;
      cur_d   = '0;
      go_d    = 1'b0;
      win_d   = '0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        act_d[i]    = (i < int'(n_clamp));
        cnt_d[i]    = '0;
        load[i]     = 1'b1;
        load_val[i] = POS_W'(start_tile(i, int'(n_clamp), RING_LEN));
      end
    end else begin
      case (state_q)
        S_READY: begin
          if (move_valid) begin
            rem_d   = move_steps;
            state_d = (move_steps == '0) ? S_RESOLVE : S_STEP;
          end
        end
        S_STEP: begin
          for (int i = 0; i < MAX_PLAYERS; i++)
            step[i] = (3'(i) == cur_q);
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) state_d = S_RESOLVE;
        end
        S_RESOLVE: begin
          if (hit) begin
            for (int i = 0; i < MAX_PLAYERS; i++) begin
              if (3'(i) == victim) begin
                load[i]     = 1'b1;
                load_val[i] = POS_W'(start_tile(i, int'(n_q), RING_LEN));
              end
              if (3'(i) == cur_q) cnt_d[i] = cnt_inc;
            end
          end
          if (hit && cnt_inc == 3'(CATCH_TO_WIN)) begin
            go_d    = 1'b1;
            win_d   = cur_q;
            state_d = S_DONE;
          end else begin
            cur_d   = nxt_player;
            state_d = S_READY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= 4'd2;
      cur_q   <= '0;
      rem_q   <= '0;
      act_q   <= '0;
      go_q    <= 1'b0;
      win_q   <= '0;
      for (int i = 0; i < MAX_PLAYERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      act_q   <= act_d;
      go_q    <= go_d;
      win_q   <= win_d;
      for (int i = 0; i < MAX_PLAYERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < MAX_PLAYERS; g++) begin : g_slot
    chicken_ring_pos #(
      .RING_LEN(RING_LEN),
      .POS_W   (POS_W)
    ) u_pos (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load[g]),
      .load_val_i(load_val[g]),
      .step_i    (step[g]),
      .pos_o     (pos_w[g])
    );
    assign pos_flat[g*POS_W +: POS_W] = pos_w[g];
    assign catch_cnt_flat[g*3 +: 3]   = cnt_q[g];
  end

  assign move_ready   = (state_q == S_READY);
  assign cur_player   = cur_q;
  assign active       = act_q;
  // A start in the resolve cycle cancels the catch, so the pulse is gated too.
  assign catch_pulse  = (state_q == S_RESOLVE) && hit && !start;
  assign catch_victim = catch_pulse ? victim : 3'd0;
  assign game_over    = go_q;
  assign winner       = win_q;

endmodule

// File: tb/tb_chicken_board_tracker.sv
// Scoreboard bench for chicken_board_tracker.
// A reference model queues each move's expected outcome; the monitor pops it.
module tb_chicken_board_tracker;

  localparam int MP = 4;
  localparam int RL = 24;
  localparam int PW = 5;
  localparam int SW = 3;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst, start, move_valid;
  logic [3:0]      N;
  logic [SW-1:0]   move_steps;
  logic            move_ready, catch_pulse, game_over;
  logic [2:0]      cur_player, catch_victim, winner;
  logic [MP*PW-1:0] pos_flat;
  logic [MP-1:0]   active;
  logic [MP*3-1:0] catch_cnt_flat;

  chicken_board_tracker #(
    .MAX_PLAYERS(MP), .RING_LEN(RL), .POS_W(PW),
    .STEP_W(SW), .CATCH_TO_WIN(CW)
  ) dut (
    .clk(clk), .rst(rst), .N(N), .start(start),
    .move_valid(move_valid), .move_steps(move_steps),
    .move_ready(move_ready), .cur_player(cur_player),
    .pos_flat(pos_flat), .active(active),
    .catch_pulse(catch_pulse), .catch_victim(catch_victim),
    .catch_cnt_flat(catch_cnt_flat),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy;
    int pulses;
    int victim;
    logic [MP*PW-1:0] flat;
    logic [MP*3-1:0] cnts;
    int cur;
    int go;
    int win;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  int m_pos[MP];
  int m_cnt[MP];
  bit m_act[MP];
  int m_n, m_cur, m_win;
  bit m_go;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [MP*PW-1:0] m_flat();
    logic [MP*PW-1:0] f;
    for (int i = 0; i < MP; i++) f[i*PW +: PW] = PW'(m_pos[i]);
    return f;
  endfunction

  function automatic logic [MP*3-1:0] m_cnts();
    logic [MP*3-1:0] f;
    for (int i = 0; i < MP; i++) f[i*3 +: 3] = 3'(m_cnt[i]);
    return f;
  endfunction

  function automatic logic [MP-1:0] m_active();
    logic [MP-1:0] a;
    for (int i = 0; i < MP; i++) a[i] = m_act[i];
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    int c;
    c = (n < 2) ? 2 : ((n > MP) ? MP : n);
    N = 4'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_n = c;
    m_cur = 0;
    m_go = 1'b0;
    m_win = 0;
    for (int i = 0; i < MP; i++) begin
      m_act[i] = (i < c);
      m_pos[i] = (i < c) ? i * (RL / c) : 0;
      m_cnt[i] = 0;
    end
    check_eq("start_pos", 32'(pos_flat), 32'(m_flat()));
    check_eq("start_active", 32'(active), 32'(m_active()));
    check_eq("start_cur", 32'(cur_player), 0);
    check_eq("start_ready", 32'(move_ready), 1);
    check_eq("start_cnts", 32'(catch_cnt_flat), 0);
    check_eq("start_go", 32'(game_over), 0);
  endtask

  task automatic do_move(input int steps);
    exp_t e, g;
    int mv, land, vic, busy, pulses, seen_vic;
    bit done;
    check_eq("ready_before_move", 32'(move_ready), 1);
    mv = m_cur;
    land = (m_pos[mv] + steps) % RL;
    vic = -1;
    for (int j = 0; j < MP; j++)
      if (vic < 0 && m_act[j] && j != mv && m_pos[j] == land) vic = j;
    m_pos[mv] = land;
    if (vic >= 0) begin
      m_pos[vic] = vic * (RL / m_n);
      if (m_cnt[mv] < 7) m_cnt[mv]++;
    end
    if (vic >= 0 && m_cnt[mv] == CW) begin
      m_go = 1'b1;
      m_win = mv;
    end else begin
      m_cur = (mv + 1) % m_n;
    end
    e.busy = steps + 1;
    e.pulses = (vic >= 0) ? 1 : 0;
    e.victim = (vic >= 0) ? vic : 0;
    e.flat = m_flat();
    e.cnts = m_cnts();
    e.cur = m_cur;
    e.go = m_go ? 1 : 0;
    e.win = m_win;
    sb.push_back(e);

    move_valid = 1'b1;
    move_steps = SW'(steps);
    tick();
    move_valid = 1'b0;

    busy = 0;
    pulses = 0;
    seen_vic = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (move_ready || game_over) begin
        done = 1'b1;
      end else begin
        busy++;
        if (catch_pulse) begin
          pulses++;
          seen_vic = int'(catch_victim);
        end
        tick();
      end
    end
    check_eq("move_timeout", 32'(done), 1);

    g = sb.pop_front();
    check_eq("busy_cycles", busy, g.busy);
    check_eq("catch_pulses", pulses, g.pulses);
    if (g.pulses != 0) check_eq("catch_victim", seen_vic, g.victim);
    check_eq("positions", 32'(pos_flat), 32'(g.flat));
    check_eq("catch_counts", 32'(catch_cnt_flat), 32'(g.cnts));
    check_eq("cur_player", 32'(cur_player), g.cur);
    check_eq("game_over", 32'(game_over), g.go);
    check_eq("winner", 32'(winner), g.win);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    move_valid = 1'b0;
    move_steps = '0;
    N = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_ready", 32'(move_ready), 0);
    check_eq("rst_pos", 32'(pos_flat), 0);
    check_eq("rst_active", 32'(active), 0);
    check_eq("rst_cur", 32'(cur_player), 0);
    check_eq("rst_cnts", 32'(catch_cnt_flat), 0);
    check_eq("rst_go", 32'(game_over), 0);
    check_eq("rst_winner", 32'(winner), 0);
    check_eq("rst_pulse", 32'(catch_pulse), 0);

    // Setup with three players.
    do_start(3);
    check_eq("n3_tiles", 32'(pos_flat), 32'({5'd0, 5'd16, 5'd8, 5'd0}));
    check_eq("n3_active", 32'(active), 32'(4'b0111));

    // Basic move.
    do_start(2);
    do_move(5);
    check_eq("basic_p0_pos", 32'(pos_flat[0 +: PW]), 5);
    check_eq("basic_cur", 32'(cur_player), 1);

    // Wrap-around by the fourth player.
    do_start(4);
    check_eq("n4_tiles", 32'(pos_flat), 32'({5'd18, 5'd12, 5'd6, 5'd0}));
    do_move(0);
    do_move(0);
    do_move(0);
    do_move(7);
    check_eq("wrap_p3_pos", 32'(pos_flat[3*PW +: PW]), 1);

    // Catch, then two more catches for the win.
    do_start(2);
    do_move(7);
    do_move(3);
    do_move(7);
    do_move(0);
    do_move(1);
    check_eq("catch_p1_home", 32'(pos_flat[PW +: PW]), 12);
    check_eq("catch_p0_cnt", 32'(catch_cnt_flat[2:0]), 1);
    do_move(4);
    do_move(1);
    do_move(5);
    do_move(1);
    check_eq("win_flag", 32'(game_over), 1);
    check_eq("win_idx", 32'(winner), 0);

    // Requests in DONE are ignored.
    move_valid = 1'b1;
    move_steps = 3'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("done_ready", 32'(move_ready), 0);
    end
    move_valid = 1'b0;
    check_eq("done_pos_held", 32'(pos_flat), 32'(m_flat()));
    check_eq("done_go_held", 32'(game_over), 1);

    // Clamping.
    do_start(9);
    check_eq("clamp9_active", 32'(active), 32'(4'b1111));
    do_start(1);
    check_eq("clamp1_active", 32'(active), 32'(4'b0011));
    check_eq("clamp1_tiles", 32'(pos_flat), 32'({5'd0, 5'd0, 5'd12, 5'd0}));
    do_start(0);
    check_eq("clamp0_active", 32'(active), 32'(4'b0011));

    // Start in the middle of a move.
    do_start(2);
    move_valid = 1'b1;
    move_steps = 3'd7;
    tick();
    move_valid = 1'b0;
    tick();
    tick();
    check_eq("midstep_busy", 32'(move_ready), 0);
    do_start(3);
    check_eq("midstep_tiles", 32'(pos_flat), 32'({5'd0, 5'd16, 5'd8, 5'd0}));
    do_move(2);

    // Reset wins over start.
    rst = 1'b1;
    start = 1'b1;
    N = 4'd3;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check_eq("rststart_ready", 32'(move_ready), 0);
    check_eq("rststart_active", 32'(active), 0);
    check_eq("rststart_pos", 32'(pos_flat), 0);
    tick();
    check_eq("rststart_idle", 32'(move_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chicken_board_tracker.md
Name: chicken_board_tracker

Overview:
- Parametrised successor to the per-player tile counter: one block tracks every player's token on the circular track.
- Responsibilities: game setup for N players, turn rotation, tile-by-tile movement with wrap-around, catch detection and a win flag.
- Sits between the card/selection logic, which issues move requests, and the display and LED drivers, which read positions.

Parameters:
- MAX_PLAYERS, 4, number of player slots supported (2..8).
- RING_LEN, 24, tiles on the track; positions 0..RING_LEN-1.
- POS_W, 5, position width; must satisfy 2^POS_W >= RING_LEN.
- STEP_W, 3, width of a move request; step 0 is legal.
- CATCH_TO_WIN, 3, catches needed by one player to win.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- N  in  4  requested player count; sampled only on a start pulse.
- start  in  1  one-cycle pulse: (re)initialise the game.
- move_valid  in  1  move request valid.
- move_steps  in  STEP_W  tiles to advance the current player.
- move_ready  out  1  high when a request can be accepted.
- cur_player  out  3  index of the player whose turn it is.
- pos_flat  out  MAX_PLAYERS*POS_W  packed positions; slot i is at bits [i*POS_W +: POS_W].
- active  out  MAX_PLAYERS  bit i is high when slot i is in play.
- catch_pulse  out  1  one-cycle pulse on a catch.
- catch_victim  out  3  victim index; valid with catch_pulse.
- catch_cnt_flat  out  MAX_PLAYERS*3  per-player catch counts, saturating at 7.
- game_over  out  1  sticky win flag.
- winner  out  3  winning player index.

Behaviour:
- Reset:
  - state=IDLE; all positions 0; active=0; cur_player=0.
  - catch counts 0; catch_pulse=0; game_over=0; winner=0; move_ready=0.
- start (any state, including mid-move):
  - Load N, clamped to the range 2..MAX_PLAYERS.
  - Slot i<N gets position i*(RING_LEN/N) using integer division. With RING_LEN=24: N=2 gives 0,12; N=3 gives 0,8,16; N=4 gives 0,6,12,18.
  - Slots with i>=N: active=0, position 0.
  - Clear catch counts and game_over; cur_player=0; go to READY on the next cycle.
  - start has priority over rst=0 activity, but rst has priority over start.
- FSM states: IDLE, READY, STEP, RESOLVE, DONE.
  - IDLE: move_ready=0; waits for start.
  - READY: move_ready=1. A handshake occurs when move_valid & move_ready in the same cycle. On a handshake, latch remaining=move_steps and go to STEP, or go straight to RESOLVE if move_steps=0.
  - STEP: advance the current player one tile per cycle; a position of RING_LEN-1 wraps to 0. Decrement remaining each cycle and go to RESOLVE when it reaches 0. Latency is move_steps cycles in STEP plus 1 cycle in RESOLVE. move_ready=0.
  - RESOLVE: compare the mover's final position with every other active slot.
    - On any match: catch_pulse=1 for one cycle; catch_victim is the lowest matching index; the mover's count increments, saturating.
    - The victim is sent back to its start tile.
    - Only one catch is counted per move, even if several slots match.
    - If the mover's count now equals CATCH_TO_WIN: game_over=1, winner=mover, go to DONE.
    - Otherwise cur_player advances to the next active index, wrapping N-1 to 0, and the block returns to READY.
  - DONE: move_ready=0; all state is held until start or rst.
- move_valid outside READY is ignored; nothing is queued.
- Intermediate tiles passed during STEP never trigger a catch; only the landing tile counts.
- An N value of 0, 1 or greater than MAX_PLAYERS is clamped and never produces an X on any output.

Decomposition:
- Shared package (chicken_pkg):
  - state enum constants;
  - RING_LEN default;
  - function start_tile(idx, n);
  - function wrap_inc(pos).
- One natural sub-module: chicken_ring_pos, a single-slot position register with load-start, step-enable and wrap. It is instantiated MAX_PLAYERS times via generate; the top level holds the FSM, turn rotation and catch logic.

Test Plan:
- Setup: start with N=3 -> next cycle pos = 0, 8, 16; active = 3'b111 (the lower three bits); cur_player = 0; move_ready = 1.
- Basic move: N=2, P0 moves 5 -> move_ready low for 6 cycles; P0 ends at 5; cur_player becomes 1; no catch_pulse.
- Wrap: N=4, P3 at 18, moves 7 -> passes 23 and lands on 1 ("passes" means reaches that tile and continues). P0 is at 0, so no catch.
- Catch:
  - N=2, P0 at 0 moves 7, then P1 at 12 moves 3 -> P1 lands on 15, no catch.
  - P0 at 7 then moves 7 -> lands on 14, no catch.
  - Force the landing case: P1 at 15 and P0 moves to 15 -> catch_pulse with victim=1; P1 is reset to 12; P0's count = 1.
- Win: three catches by P0 with CATCH_TO_WIN=3 -> game_over=1, winner=0; move_ready stays 0 until start.
- Clamping and control edges:
  - N=9 is clamped to 4 and N=1 to 2.
  - A start issued mid-STEP reinitialises the game.
  - rst asserted together with start leaves the block in IDLE.
